// File: rtl/lab3_pkg.sv
// Shared definitions for the Lab3 tail-light display: mode encoding,
// sequencer states, lamp patterns and the state-to-output helpers.
package lab3_pkg;

   typedef enum logic [2:0] {
      MODE_IDLE       = 3'd0,
      MODE_HAZARDS    = 3'd1,
      MODE_TURN_LEFT  = 3'd2,
      MODE_TURN_RIGHT = 3'd3
   } mode_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_L1   = 3'd1,
      S_L2   = 3'd2,
      S_L3   = 3'd3,
      S_R1   = 3'd4,
      S_R2   = 3'd5,
      S_R3   = 3'd6,
      S_HAZ  = 3'd7
   } seq_state_t;

   // LEDR[5:3] = LC,LB,LA and LEDR[2:0] = RA,RB,RC
   localparam logic [5:0] LED_OFF = 6'b000_000;
   localparam logic [5:0] LED_L1  = 6'b001_000;
   localparam logic [5:0] LED_L2  = 6'b011_000;
   localparam logic [5:0] LED_L3  = 6'b111_000;
   localparam logic [5:0] LED_R1  = 6'b000_100;
   localparam logic [5:0] LED_R2  = 6'b000_110;
   localparam logic [5:0] LED_R3  = 6'b000_111;
   localparam logic [5:0] LED_HAZ = 6'b111_111;

   // Request codes 4-7 fall through to the default branches and act as idle.
   function automatic seq_state_t next_state(input seq_state_t cur, input logic [2:0] req);
      seq_state_t nxt;
      nxt = S_IDLE;
      case (cur)
         S_IDLE: begin
            case (req)
               MODE_HAZARDS:    nxt = S_HAZ;
               MODE_TURN_LEFT:  nxt = S_L1;
               MODE_TURN_RIGHT: nxt = S_R1;
               default:         nxt = S_IDLE;
            endcase
         end
         S_L1:    nxt = (req == MODE_HAZARDS) ? S_HAZ : S_L2;
         S_L2:    nxt = (req == MODE_HAZARDS) ? S_HAZ : S_L3;
         S_L3:    nxt = (req == MODE_HAZARDS) ? S_HAZ : S_IDLE;
         S_R1:    nxt = (req == MODE_HAZARDS) ? S_HAZ : S_R2;
         S_R2:    nxt = (req == MODE_HAZARDS) ? S_HAZ : S_R3;
         S_R3:    nxt = (req == MODE_HAZARDS) ? S_HAZ : S_IDLE;
         S_HAZ:   nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      return nxt;
   endfunction

   function automatic logic [5:0] led_pattern(input seq_state_t st);
      logic [5:0] p;
      p = LED_OFF;
      case (st)
         S_L1:    p = LED_L1;
         S_L2:    p = LED_L2;
         S_L3:    p = LED_L3;
         S_R1:    p = LED_R1;
         S_R2:    p = LED_R2;
         S_R3:    p = LED_R3;
         S_HAZ:   p = LED_HAZ;
         default: p = LED_OFF;
      endcase
      return p;
   endfunction

   function automatic logic [2:0] state_mode(input seq_state_t st);
      logic [2:0] m;
      m = MODE_IDLE;
      case (st)
         S_L1, S_L2, S_L3: m = MODE_TURN_LEFT;
         S_R1, S_R2, S_R3: m = MODE_TURN_RIGHT;
         S_HAZ:            m = MODE_HAZARDS;
         default:          m = MODE_IDLE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/tail_light_sequencer_tick_gen.sv
// Prescaler: free-running 0..TICK_DIV-1 counter with a one-cycle
// terminal-count pulse that paces the light sequence.
module tick_gen #(
   parameter int TICK_DIV = 12_500_000
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   output logic step_tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign step_tick = (cnt == CW'(TICK_DIV - 1));

   // Count up and wrap on the terminal count.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt <= '0;
      end else if (step_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: steps six lamps through left/right/hazard
// patterns, advancing only on the prescaled step tick.
//
// state  | meaning
// IDLE   | all lamps off, waiting for a request
// L1..L3 | left turn: LA, LA+LB, LA+LB+LC
// R1..R3 | right turn: RA, RA+RB, RA+RB+RC
// HAZ    | all lamps on (blink phase of hazards)
module tail_light_sequencer
   import lab3_pkg::*;
#(
   parameter int TICK_DIV = 12_500_000
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic [2:0] mode_req,
   output logic [5:0] LEDR,
   output logic [2:0] active_mode,
   output logic       step_tick
);

   seq_state_t state;
   seq_state_t next_st;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .CLOCK_50  (CLOCK_50),
      .RESET_N   (RESET_N),
      .step_tick (step_tick)
   );

   // Next state from the current state and the request sampled at the tick.
   always_comb begin
      next_st = next_state(state, mode_req);
   end

   // State and lamp/mode outputs update together, only on a tick edge.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= S_IDLE;
         LEDR        <= LED_OFF;
         active_mode <= MODE_IDLE;
      end else if (step_tick) begin
         state       <= next_st;
         LEDR        <= led_pattern(next_st);
         active_mode <= state_mode(next_st);
      end
   end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Self-checking bench for tail_light_sequencer with TICK_DIV=4.
// Reference model: sequence kind (0 idle, 1 hazard, 2 left, 3 right) plus
// lamp count; lamp patterns are computed arithmetically from the count.
module tb_tail_light_sequencer;

   localparam int DIV = 4;

   logic       clk;
   logic       rst_n;
   logic [2:0] mode_req;
   logic [5:0] ledr;
   logic [2:0] active_mode;
   logic       step_tick;

   int tests = 0;
   int fails = 0;

   // model state
   int m_kind;   // 0 idle, 1 hazard, 2 left, 3 right
   int m_lit;    // lamps lit in a turn sequence, 1..3
   int m_cyc;    // cycles since reset release

   tail_light_sequencer #(.TICK_DIV(DIV)) dut (
      .CLOCK_50    (clk),
      .RESET_N     (rst_n),
      .mode_req    (mode_req),
      .LEDR        (ledr),
      .active_mode (active_mode),
      .step_tick   (step_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] exp_leds();
      case (m_kind)
         1:       return 6'b111111;
         2:       return 6'(((1 << m_lit) - 1) << 3);
         3:       return 6'((7 << (3 - m_lit)) & 7);
         default: return 6'b000000;
      endcase
   endfunction

   function automatic bit exp_tick();
      return ((m_cyc % DIV) == DIV - 1);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input int req);
      if (m_kind == 0) begin
         if (req >= 1 && req <= 3) begin
            m_kind = req;
            m_lit  = 1;
         end
      end else if (m_kind == 1) begin
         m_kind = 0;
      end else if (req == 1) begin
         m_kind = 1;
      end else if (m_lit == 3) begin
         m_kind = 0;
      end else begin
         m_lit++;
      end
   endtask

   // Called just after a falling edge: drive, check tick, clock, check outputs.
   task automatic cycle(input int req);
      bit t;
      mode_req = 3'(req);
      t = exp_tick();
      chk("step_tick", {7'd0, step_tick}, {7'd0, t});
      @(posedge clk);
      if (t) model_step(req);
      m_cyc++;
      @(negedge clk);
      chk("LEDR", {2'd0, ledr}, {2'd0, exp_leds()});
      chk("active_mode", {5'd0, active_mode}, 8'(m_kind));
   endtask

   task automatic run(input int req, input int n);
      for (int i = 0; i < n; i++) cycle(req);
   endtask

   // Assert reset between edges, check it acts immediately, release at a falling edge.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_LEDR", {2'd0, ledr}, 8'd0);
      chk("rst_mode", {5'd0, active_mode}, 8'd0);
      chk("rst_tick", {7'd0, step_tick}, 8'd0);
      m_kind = 0;
      m_lit  = 0;
      m_cyc  = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int guard;
      rst_n    = 1'b0;
      mode_req = 3'd0;
      m_kind   = 0;
      m_lit    = 0;
      m_cyc    = 0;
      repeat (3) @(negedge clk);

      // 1. reset / idle
      chk("reset_LEDR", {2'd0, ledr}, 8'd0);
      chk("reset_mode", {5'd0, active_mode}, 8'd0);
      chk("reset_tick", {7'd0, step_tick}, 8'd0);
      rst_n = 1'b1;
      run(0, 40);

      // 2. left turn held for three full periods
      run(2, 48);
      run(0, 8);

      // 3. right turn, switch to left once R1 is lit
      guard = 0;
      while (!(m_kind == 3 && m_lit == 1) && guard < 20) begin
         cycle(3);
         guard++;
      end
      chk("reach_R1", {2'd0, ledr}, 8'b000100);
      run(2, 16);
      run(0, 12);

      // 4. hazard preempts L2
      guard = 0;
      while (!(m_kind == 2 && m_lit == 2) && guard < 30) begin
         cycle(2);
         guard++;
      end
      chk("reach_L2", {2'd0, ledr}, 8'b011000);
      run(1, 20);
      run(0, 8);

      // 5. async reset in L3, then left turn lights on the 4th edge
      guard = 0;
      while (!(m_kind == 2 && m_lit == 3) && guard < 30) begin
         cycle(2);
         guard++;
      end
      chk("reach_L3", {2'd0, ledr}, 8'b111000);
      async_reset();
      run(2, 3);
      chk("post_rst_dark", {2'd0, ledr}, 8'd0);
      cycle(2);
      chk("post_rst_4th", {2'd0, ledr}, 8'b001000);
      run(0, 12);

      // 6. invalid mode held, then an off-tick left pulse
      run(5, 20);
      run(7, 8);
      guard = 0;
      while ((m_cyc % DIV) != 0 && guard < 8) begin
         cycle(0);
         guard++;
      end
      cycle(2);
      run(0, 8);
      chk("glitch_ignored", {2'd0, ledr}, 8'd0);

      // randomized requests, with occasional long holds so sequences complete
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 7);
         run(r, $urandom_range(1, 12));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
